// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and width helpers for the exhaustive truth-table sweeper.
package truth_table_sweeper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } tts_state_t;

    function automatic int unsigned tts_nvec(input int unsigned n_in);
        return 32'd1 << n_in;
    endfunction

    function automatic int unsigned tts_errw(input int unsigned n_in, input int unsigned n_ch);
        return n_in + 32'($clog2(n_ch)) + 32'd1;
    endfunction

    function automatic int unsigned tts_chw(input int unsigned n_ch);
        return (n_ch > 32'd1) ? 32'($clog2(n_ch)) : 32'd1;
    endfunction

    function automatic int unsigned tts_pcw(input int unsigned n_ch);
        return 32'($clog2(n_ch + 32'd1));
    endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Control, golden-table, DUT and result signals of one sweeper instance.
interface truth_table_sweeper_if
    import truth_table_sweeper_pkg::*;
#(
    parameter int unsigned N_IN = 4,
    parameter int unsigned N_CH = 8
);
    localparam int unsigned NVEC = tts_nvec(N_IN);
    localparam int unsigned ERRW = tts_errw(N_IN, N_CH);
    localparam int unsigned CHW  = tts_chw(N_CH);

    logic                   start;
    logic                   abort;
    logic [N_CH*NVEC-1:0]   expected;
    logic [N_CH-1:0]        dut_y;
    logic [N_IN-1:0]        vec;
    logic                   sample_valid;
    logic [N_CH-1:0]        mismatch;
    logic                   busy;
    logic                   done;
    logic                   pass;
    logic [ERRW-1:0]        err_count;
    logic [N_IN-1:0]        first_err_vec;
    logic [CHW-1:0]         first_err_ch;

    modport master (
        output start, abort, expected, dut_y,
        input  vec, sample_valid, mismatch, busy, done, pass,
               err_count, first_err_vec, first_err_ch
    );

    modport slave (
        input  start, abort, expected, dut_y,
        output vec, sample_valid, mismatch, busy, done, pass,
               err_count, first_err_vec, first_err_ch
    );

endinterface

// File: rtl/truth_table_sweeper_tt_compare.sv
// Combinational compare of all channels against their golden bit for the current vector.
module tt_compare
    import truth_table_sweeper_pkg::*;
#(
    parameter  int unsigned N_IN = 4,
    parameter  int unsigned N_CH = 8,
    localparam int unsigned NVEC = tts_nvec(N_IN),
    localparam int unsigned CHW  = tts_chw(N_CH),
    localparam int unsigned PCW  = tts_pcw(N_CH)
) (
    input  logic [N_IN-1:0]      i_vec,
    input  logic [N_CH*NVEC-1:0] i_expected,
    input  logic [N_CH-1:0]      i_dut_y,
    output logic [N_CH-1:0]      o_mismatch_c,
    output logic [PCW-1:0]       o_popcount_c,
    output logic [CHW-1:0]       o_low_ch_c,
    output logic                 o_any_c
);

    logic [NVEC-1:0] w_row;

    always_comb begin
        w_row        = '0;
        o_mismatch_c = '0;
        o_popcount_c = '0;
        o_low_ch_c   = '0;
        for (int c = 0; c < int'(N_CH); c++) begin
            w_row           = i_expected[c*NVEC +: NVEC];
            o_mismatch_c[c] = i_dut_y[c] ^ w_row[i_vec];
        end
        for (int c = int'(N_CH) - 1; c >= 0; c--) begin
            if (o_mismatch_c[c]) begin
                o_low_ch_c = CHW'(c);
            end
        end
        for (int c = 0; c < int'(N_CH); c++) begin
            o_popcount_c = o_popcount_c + PCW'(o_mismatch_c[c]);
        end
    end

    assign o_any_c = |o_mismatch_c;

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper: walks every input vector, samples N_CH channels
// after a settle interval and accumulates mismatch statistics.
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int unsigned N_IN   = 4,
    parameter int unsigned N_CH   = 8,
    parameter int unsigned SETTLE = 1,
    parameter int unsigned CONT   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    truth_table_sweeper_if.slave  bus
);

    localparam int unsigned NVEC = tts_nvec(N_IN);
    localparam int unsigned ERRW = tts_errw(N_IN, N_CH);
    localparam int unsigned CHW  = tts_chw(N_CH);
    localparam int unsigned PCW  = tts_pcw(N_CH);
    localparam int unsigned SUMW = ERRW + 1;
    localparam int unsigned CNTW = 8;

    tts_state_t        r_state;
    logic [N_IN-1:0]   r_vec;
    logic [CNTW-1:0]   r_settle_cnt;
    logic              r_sample_valid;
    logic [N_CH-1:0]   r_mismatch;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic [ERRW-1:0]   r_err_count;
    logic [N_IN-1:0]   r_first_err_vec;
    logic [CHW-1:0]    r_first_err_ch;
    logic              r_first_flag;

    logic [N_CH-1:0]   w_mismatch;
    logic [PCW-1:0]    w_popcount;
    logic [CHW-1:0]    w_low_ch;
    logic              w_any;
    logic [SUMW-1:0]   w_err_sum;
    logic [ERRW-1:0]   w_err_next;
    logic              w_last;
    logic              w_abort;
    logic              w_start;

    tt_compare #(
        .N_IN (N_IN),
        .N_CH (N_CH)
    ) u_cmp (
        .i_vec        (r_vec),
        .i_expected   (bus.expected),
        .i_dut_y      (bus.dut_y),
        .o_mismatch_c (w_mismatch),
        .o_popcount_c (w_popcount),
        .o_low_ch_c   (w_low_ch),
        .o_any_c      (w_any)
    );

    // Saturating error accumulation: one extra bit catches the overflow.
    assign w_err_sum  = SUMW'(r_err_count) + SUMW'(w_popcount);
    assign w_err_next = w_err_sum[ERRW] ? '1 : w_err_sum[ERRW-1:0];
    assign w_last     = (r_vec == N_IN'(NVEC - 1));

    // Abort beats start; a finished sweep restarts on start or in continuous mode.
    assign w_abort = bus.abort && (r_state != ST_IDLE);
    assign w_start = !w_abort &&
                     (((r_state == ST_IDLE) && bus.start) ||
                      ((r_state == ST_DONE) && (bus.start || (CONT != 0))));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_vec           <= '0;
            r_settle_cnt    <= '0;
            r_sample_valid  <= 1'b0;
            r_mismatch      <= '0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_pass          <= 1'b0;
            r_err_count     <= '0;
            r_first_err_vec <= '0;
            r_first_err_ch  <= '0;
            r_first_flag    <= 1'b0;
        end else if (w_abort) begin
            r_state        <= ST_IDLE;
            r_vec          <= '0;
            r_settle_cnt   <= '0;
            r_sample_valid <= 1'b0;
            r_mismatch     <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_pass         <= 1'b0;
        end else if (w_start) begin
            r_state         <= ST_APPLY;
            r_vec           <= '0;
            r_settle_cnt    <= '0;
            r_sample_valid  <= 1'b0;
            r_mismatch      <= '0;
            r_busy          <= 1'b1;
            r_done          <= 1'b0;
            r_pass          <= 1'b0;
            r_err_count     <= '0;
            r_first_err_vec <= '0;
            r_first_err_ch  <= '0;
            r_first_flag    <= 1'b0;
        end else begin
            case (r_state)
                ST_APPLY: begin
                    // dut_y is captured on the edge that ends the settle window.
                    if (r_settle_cnt == CNTW'(SETTLE - 1)) begin
                        r_state        <= ST_SAMPLE;
                        r_sample_valid <= 1'b1;
                        r_mismatch     <= w_mismatch;
                        r_err_count    <= w_err_next;
                        if (w_any && !r_first_flag) begin
                            r_first_err_vec <= r_vec;
                            r_first_err_ch  <= w_low_ch;
                            r_first_flag    <= 1'b1;
                        end
                    end else begin
                        r_settle_cnt <= r_settle_cnt + CNTW'(1);
                    end
                end
                ST_SAMPLE: begin
                    r_sample_valid <= 1'b0;
                    r_mismatch     <= '0;
                    r_settle_cnt   <= '0;
                    if (w_last) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (r_err_count == '0);
                    end else begin
                        r_state <= ST_APPLY;
                        r_vec   <= r_vec + N_IN'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.vec           = r_vec;
    assign bus.sample_valid  = r_sample_valid;
    assign bus.mismatch      = r_mismatch;
    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.pass          = r_pass;
    assign bus.err_count     = r_err_count;
    assign bus.first_err_vec = r_first_err_vec;
    assign bus.first_err_ch  = r_first_err_ch;

endmodule
